round_robin_mux_arbiter: RTL and testbench

ROUND_ROBIN_MUX_ARBITER -- requirements
Module: round_robin_mux_arbiter

---
 rtl/round_robin_mux_arbiter_pkg.sv | 39 +++
 rtl/fourToOneMux.sv | 11 +
 rtl/round_robin_mux_arbiter.sv | 112 +++++++++++
 tb/tb_round_robin_mux_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/round_robin_mux_arbiter_pkg.sv
// rtl/round_robin_mux_arbiter_pkg.sv - shared types, constants and round-robin search helper
// Purpose: arbiter FSM state enum, requester count, select width, winner search.
package round_robin_mux_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set request bit at or after ptr, wrapping modulo NUM_REQ.
  // Iterating from the farthest candidate down lets the nearest one win last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req_v,
                                    input logic [SEL_W-1:0]   ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + k[SEL_W-1:0];
      if (req_v[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/fourToOneMux.sv
// rtl/fourToOneMux.sv - shared 4:1 single-bit data multiplexer
// Ports: d[3:0] data inputs, s[1:0] select, y = d[s].
module fourToOneMux (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  assign y = d[s];

endmodule

// File: rtl/round_robin_mux_arbiter.sv
// rtl/round_robin_mux_arbiter.sv - 4-requester round-robin arbiter driving a shared 4:1 data mux
// Ports: clk, rst_n (async, active-low); req[3:0], data_in[3:0] per requester;
//        out_ready from sink; grant[3:0] one-hot, sel[1:0] mux select,
//        data_out = data_in[sel], out_valid = transfer present.
module round_robin_mux_arbiter
  import round_robin_mux_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               data_out,
  output logic               out_valid
);

  localparam logic [3:0] LAST_XFER = 4'(MAX_BURST - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;

  logic                 valid;
  logic                 xfer;
  logic                 release_now;
  logic [SEL_W-1:0]     ptr_rel;
  pick_t                pick_idle;
  pick_t                pick_rel;

  assign valid       = (state_q == GRANT) && req[sel_q];
  assign xfer        = valid && out_ready;
  assign release_now = (state_q == GRANT) &&
                       (!req[sel_q] || (xfer && (cnt_q == LAST_XFER)));
  // Searching from sel+1 puts the releasing requester last in line.
  assign ptr_rel     = sel_q + 2'd1;
  assign pick_idle   = rr_pick(req, ptr_q);
  assign pick_rel    = rr_pick(req, ptr_rel);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_d = GRANT;
          grant_d = onehot(pick_idle.idx);
          sel_d   = pick_idle.idx;
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
        if (release_now) begin
          ptr_d = ptr_rel;
          cnt_d = 4'd0;
          if (pick_rel.found) begin
            grant_d = onehot(pick_rel.idx);
            sel_d   = pick_rel.idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            sel_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      cnt_q   <= 4'd0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = valid;

  fourToOneMux u_mux (
    .d (data_in),
    .s (sel_q),
    .y (data_out)
  );

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// tb/tb_round_robin_mux_arbiter.sv - scoreboard bench for round_robin_mux_arbiter
module tb_round_robin_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] data_in;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       data_out;
  logic       out_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  bit sb_en    = 1'b1;
  bit rnd_en   = 1'b0;

  logic [2:0] exp_q[$];
  logic [2:0] item;
  logic [3:0] prev_grant;
  int         wait_chg[4];

  round_robin_mux_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected transfer: {sel, data bit of that requester under current data_in}.
  task automatic expect_x(input int s, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({2'(s), data_in[s]});
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    cycles(2);
    check(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: scoreboard pop on every transfer; invariants during random run.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfer_cnt++;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", int'(sel), -1);
        end else begin
          item = exp_q.pop_front();
          check("xfer_sel", int'(sel), int'(item[2:1]));
          check("xfer_data", int'(data_out), int'(item[0]));
          check("xfer_grant", int'(grant), int'(4'b0001 << item[2:1]));
        end
      end
    end
    if (rnd_en && rst_n) begin
      check("onehot0", int'($onehot0(grant)), 1);
      check("data_mux", int'(data_out), int'(data_in[sel]));
      if (grant != 4'b0000) check("sel_enc", int'(grant), int'(4'b0001 << sel));
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || grant[i]) begin
          wait_chg[i] = 0;
        end else if (grant != prev_grant && grant != 4'b0000) begin
          wait_chg[i]++;
          check("starve", int'(wait_chg[i] <= 3), 1);
        end
      end
      prev_grant = grant;
    end else begin
      prev_grant = 4'b0000;
      for (int i = 0; i < 4; i++) wait_chg[i] = 0;
    end
  end

  initial begin
    int x0;
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    data_in   = 4'b0101;
    cycles(2);
    check("rst_grant", int'(grant), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(data_out), 1);

    // All requesting: 0,1,2,3,0 with four back-to-back transfers each.
    do_reset();
    data_in = 4'b1010;
    req = 4'b1111; out_ready = 1'b1;
    x0 = xfer_cnt;
    expect_x(0, 4); expect_x(1, 4); expect_x(2, 4); expect_x(3, 4); expect_x(0, 4);
    cycles(21);
    req = 4'b0000;
    check("rr_xfer_count", xfer_cnt - x0, 20);
    drain("rr_queue_empty");

    // Lone requester 2: burst, immediate re-grant, then ptr=3 seen on next search.
    do_reset();
    data_in = 4'b0100;
    req = 4'b0100; out_ready = 1'b1;
    expect_x(2, 6);
    cycles(7);
    req = 4'b0000;
    cycles(2);
    check("lone_idle_grant", int'(grant), 0);
    check("lone_queue_empty", exp_q.size(), 0);
    req = 4'b1111;
    expect_x(3, 4);
    cycles(5);
    req = 4'b0000;
    drain("ptr3_queue_empty");

    // Stall on requester 1; requester 0 raised mid-tenure must wait.
    do_reset();
    data_in = 4'b0010;
    req = 4'b0010; out_ready = 1'b0;
    cycles(1);
    req = 4'b0011;
    x0 = xfer_cnt;
    cycles(5);
    check("stall_grant", int'(grant), 4'b0010);
    check("stall_valid", int'(out_valid), 1);
    check("stall_no_xfer", xfer_cnt - x0, 0);
    out_ready = 1'b1;
    expect_x(1, 4); expect_x(0, 2);
    cycles(6);
    req = 4'b0000;
    drain("stall_queue_empty");

    // Requester 3 drops after 2 transfers; pointer wraps to 0.
    do_reset();
    data_in = 4'b1001;
    req = 4'b1000; out_ready = 1'b1;
    expect_x(3, 2); expect_x(0, 1);
    cycles(3);
    req = 4'b0011;
    cycles(1);
    check("wrap_grant", int'(grant), 4'b0001);
    cycles(1);
    req = 4'b0000;
    drain("wrap_queue_empty");

    // Reset mid-burst on requester 2.
    do_reset();
    data_in = 4'b0011;
    req = 4'b0100; out_ready = 1'b1;
    expect_x(2, 2);
    cycles(3);
    rst_n = 1'b0;
    req = 4'b1111;
    #1;
    check("midrst_grant", int'(grant), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_sel", int'(sel), 0);
    check("midrst_data", int'(data_out), 1);
    cycles(2);
    rst_n = 1'b1;
    expect_x(0, 1);
    cycles(1);
    check("postrst_grant", int'(grant), 4'b0001);
    cycles(1);
    req = 4'b0000;
    drain("midrst_queue_empty");

    // Random traffic with invariant checks.
    do_reset();
    sb_en  = 1'b0;
    rnd_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      end
      out_ready = ($urandom_range(3) != 0);
      data_in   = 4'($urandom);
      cycles(1);
    end
    rnd_en = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
